// File: rtl/series_pkg.sv
// rtl/series_pkg.sv - shared state encoding, mode constants and coefficient builder for series_eval_engine
package series_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MUL_X1,
        S_MUL_X2,
        S_MUL_C,
        S_CHECK,
        S_ACC,
        S_DONE
    } state_t;

    localparam logic MODE_COS = 1'b0;
    localparam logic MODE_SIN = 1'b1;

    // Round-to-nearest Q-format reciprocal of the term-k divisor; slots outside 1..max_terms-1 read 0.
    function automatic longint coef_word(input int width, input int frac, input logic mode,
                                         input int k, input int max_terms);
        longint d;
        longint c;
        longint lim;
        if (k < 1 || k >= max_terms) return 0;
        if (mode == MODE_COS) d = longint'(2 * k - 1) * longint'(2 * k);
        else                  d = longint'(2 * k) * longint'(2 * k + 1);
        c   = ((longint'(1) <<< frac) + d / 2) / d;
        lim = (longint'(1) <<< (width - 1)) - 1;
        if (c > lim) c = lim;
        return c;
    endfunction

endpackage

// File: rtl/series_coef_rom.sv
// rtl/series_coef_rom.sv - combinational (mode, k) to series coefficient lookup
module series_coef_rom
    import series_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FRAC      = 14,
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic                    i_mode,
    input  logic [CNT_W-1:0]        i_k,
    output logic signed [WIDTH-1:0] o_coef
);

    logic [WIDTH-1:0] w_cos [2**CNT_W];
    logic [WIDTH-1:0] w_sin [2**CNT_W];

    for (genvar g = 0; g < 2**CNT_W; g++) begin : g_tab
        assign w_cos[g] = WIDTH'(coef_word(WIDTH, FRAC, MODE_COS, g, MAX_TERMS));
        assign w_sin[g] = WIDTH'(coef_word(WIDTH, FRAC, MODE_SIN, g, MAX_TERMS));
    end

    assign o_coef = (i_mode == MODE_SIN) ? w_sin[i_k] : w_cos[i_k];

endmodule

// File: rtl/series_eval_engine.sv
// rtl/series_eval_engine.sv - fixed-point Taylor cos/sin evaluator; SERIES_SAT_EN selects saturating arithmetic
module series_eval_engine
    import series_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FRAC      = 14,
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_mode,
    input  logic signed [WIDTH-1:0] i_x_in,
    input  logic [WIDTH-1:0]        i_thr,
    output logic signed [WIDTH-1:0] o_result,
    output logic [CNT_W-1:0]        o_terms_used,
    output logic                    o_busy,
    output logic                    o_ready,
    output logic                    o_done
);

    localparam logic signed [WIDTH-1:0] L_ONE = WIDTH'(1) << FRAC;

    state_t                    r_state, w_next;
    logic signed [WIDTH-1:0]   r_x, r_term, r_result;
    logic [WIDTH-1:0]          r_thr;
    logic                      r_mode;
    logic [CNT_W-1:0]          r_k, r_terms_used;

    logic signed [WIDTH-1:0]   w_coef, w_b, w_mul, w_acc;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [WIDTH:0]     w_sum;
    logic [WIDTH:0]            w_abs;
    logic                      w_stop;

    function automatic logic signed [WIDTH-1:0] f_fit(input logic signed [2*WIDTH-1:0] v);
`ifdef SERIES_SAT_EN
        logic signed [2*WIDTH-1:0] hi, lo;
        hi = {{WIDTH{1'b0}}, 1'b0, {(WIDTH-1){1'b1}}};
        lo = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
        if (v > hi)      return WIDTH'(hi);
        else if (v < lo) return WIDTH'(lo);
        else             return WIDTH'(v);
`else
        return WIDTH'(v);
`endif
    endfunction

    series_coef_rom #(
        .WIDTH(WIDTH), .FRAC(FRAC), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)
    ) u_rom (
        .i_mode(r_mode),
        .i_k   (r_k),
        .o_coef(w_coef)
    );

    // One shared multiplier: x in the two MUL_X stages, the coefficient in MUL_C.
    assign w_b    = (r_state == S_MUL_C) ? w_coef : r_x;
    assign w_prod = (2*WIDTH)'(r_term) * (2*WIDTH)'(w_b);
    assign w_mul  = f_fit(w_prod >>> FRAC);
    assign w_sum  = r_k[0] ? ((WIDTH+1)'(r_result) - (WIDTH+1)'(r_term))
                           : ((WIDTH+1)'(r_result) + (WIDTH+1)'(r_term));
    assign w_acc  = f_fit((2*WIDTH)'(w_sum));
    assign w_abs  = r_term[WIDTH-1] ? -(WIDTH+1)'(r_term) : (WIDTH+1)'(r_term);
    assign w_stop = (r_term == '0) || (w_abs < {1'b0, r_thr});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = i_start ? S_INIT : S_IDLE;
            S_INIT:   w_next = S_MUL_X1;
            S_MUL_X1: w_next = S_MUL_X2;
            S_MUL_X2: w_next = S_MUL_C;
            S_MUL_C:  w_next = S_CHECK;
            S_CHECK:  w_next = w_stop ? S_DONE : S_ACC;
            S_ACC:    w_next = (r_k == CNT_W'(MAX_TERMS - 1)) ? S_DONE : S_MUL_X1;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = 1'b0;
        o_ready = 1'b0;
        o_done  = 1'b0;
        o_busy  = (r_state != S_IDLE);
        o_ready = (r_state == S_IDLE);
        o_done  = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x          <= '0;
            r_thr        <= '0;
            r_mode       <= MODE_COS;
            r_term       <= '0;
            r_result     <= '0;
            r_terms_used <= '0;
            r_k          <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_x          <= i_x_in;
                    r_mode       <= i_mode;
                    r_thr        <= i_thr;
                    r_term       <= (i_mode == MODE_SIN) ? i_x_in : L_ONE;
                    r_result     <= (i_mode == MODE_SIN) ? i_x_in : L_ONE;
                    r_terms_used <= CNT_W'(1);
                    r_k          <= CNT_W'(1);
                end
                S_MUL_X1, S_MUL_X2, S_MUL_C: r_term <= w_mul;
                S_ACC: begin
                    r_result     <= w_acc;
                    r_terms_used <= r_terms_used + 1'b1;
                    if (r_k != CNT_W'(MAX_TERMS - 1)) r_k <= r_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_result     = r_result;
    assign o_terms_used = r_terms_used;

endmodule
